// File: rtl/adder_acc_ctrl.sv
// adder_acc_ctrl: mode/psum sequencer for the CNN 3-input row adder; ADDER_ACC_CTRL_RELU_EN drives relu_en from out_valid.
module adder_acc_ctrl #(
   parameter int CH_W  = 8,
   parameter int PIX_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CH_W-1:0]  cfg_num_ch,
   input  logic [PIX_W-1:0] cfg_num_pix,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [1:0]       add_mode,
   output logic             psum_clr,
   output logic [PIX_W-1:0] psum_raddr,
   output logic [PIX_W-1:0] psum_waddr,
   output logic             psum_we,
   output logic             psum_fwd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             relu_en
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam logic [CH_W-1:0]  CH_ONE  = 1;
   localparam logic [PIX_W-1:0] PIX_ONE = 1;
   state_t           state;
   logic [CH_W-1:0]  ch, n_ch;
   logic [PIX_W-1:0] pix, n_pix;
   logic             accept, last_ch, last_pix;
   assign last_ch    = ch == n_ch - CH_ONE;
   assign last_pix   = pix == n_pix - PIX_ONE;
   assign in_ready   = state == RUN && !(out_valid && !out_ready);
   assign accept     = in_valid && in_ready;
   assign add_mode   = !accept ? 2'd0 : last_ch ? 2'd2 : ch == '0 ? 2'd0 : 2'd1;
   assign psum_clr   = accept && ch == '0;
   assign psum_raddr = accept ? pix : '0;
   // the buffer write lands one cycle late, so a same-address read must take the registered Result
   assign psum_fwd   = accept && psum_we && psum_waddr == pix;
   assign busy       = state == RUN || state == DRAIN;
   assign done       = state == DONE;
`ifdef ADDER_ACC_CTRL_RELU_EN
   assign relu_en    = out_valid;
`else
   assign relu_en    = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ch         <= '0;
         pix        <= '0;
         n_ch       <= '0;
         n_pix      <= '0;
         psum_we    <= 1'b0;
         psum_waddr <= '0;
         out_valid  <= 1'b0;
      end else begin
         psum_we    <= accept && !last_ch;
         psum_waddr <= (accept && !last_ch) ? pix : '0;
         out_valid  <= (accept && last_ch) || (out_valid && !out_ready);
         case (state)
            IDLE: if (start) begin
               n_ch  <= cfg_num_ch == '0 ? CH_ONE : cfg_num_ch;
               n_pix <= cfg_num_pix == '0 ? PIX_ONE : cfg_num_pix;
               ch    <= '0;
               pix   <= '0;
               state <= RUN;
            end
            RUN: if (accept) begin
               pix <= last_pix ? '0 : pix + PIX_ONE;
               if (last_pix) ch <= ch + CH_ONE;
               if (last_pix && last_ch) state <= DRAIN;
            end
            DRAIN: if (!out_valid || out_ready) state <= DONE;
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adder_acc_ctrl.sv
// tb_adder_acc_ctrl: directed and randomized tiles checked against a beat-index reference model.
module tb_adder_acc_ctrl;
   logic       clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
   logic [7:0] cfg_num_ch = 0;
   logic [9:0] cfg_num_pix = 0;
   logic       in_ready, psum_clr, psum_we, psum_fwd, out_valid, busy, done, relu_en;
   logic [1:0] add_mode;
   logic [9:0] psum_raddr, psum_waddr;
   int checks = 0, errors = 0;

   adder_acc_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .cfg_num_ch(cfg_num_ch), .cfg_num_pix(cfg_num_pix),
      .in_valid(in_valid), .in_ready(in_ready), .add_mode(add_mode), .psum_clr(psum_clr),
      .psum_raddr(psum_raddr), .psum_waddr(psum_waddr), .psum_we(psum_we), .psum_fwd(psum_fwd),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .relu_en(relu_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic relu_exp(input logic ov);
`ifdef ADDER_ACC_CTRL_RELU_EN
      return ov;
`else
      return 1'b0;
`endif
   endfunction

   task automatic idle_checks(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_we"}, psum_we, 0);
      chk({tag, "_waddr"}, psum_waddr, 0);
      chk({tag, "_mode"}, add_mode, 0);
      chk({tag, "_clr"}, psum_clr, 0);
      chk({tag, "_raddr"}, psum_raddr, 0);
      chk({tag, "_fwd"}, psum_fwd, 0);
      chk({tag, "_relu"}, relu_en, 0);
   endtask

   // mode 0: back-to-back; 1: random valid/ready/start; 2: out_ready low 5 cycles at first result
   task automatic run_tile(input int nch, input int npix, input int mode);
      int ne, np, total, k, cyc, hs_cnt, stall, c, p;
      logic exp_ov, exp_we, acc, hs, ir;
      logic [9:0] exp_wa;
      ne = nch == 0 ? 1 : nch;
      np = npix == 0 ? 1 : npix;
      total = ne * np;
      k = 0; cyc = 0; hs_cnt = 0; stall = 0;
      exp_ov = 0; exp_we = 0; exp_wa = 0;
      @(negedge clk);
      start = 1; cfg_num_ch = 8'(nch); cfg_num_pix = 10'(npix); in_valid = 0; out_ready = 1;
      @(negedge clk);
      start = 0;
      while (!(k == total && !exp_ov) && cyc < 4000) begin
         cyc++;
         in_valid  = mode == 1 ? ($urandom % 4 != 0) : 1'b1;
         out_ready = mode == 1 ? ($urandom % 3 != 0) : !(mode == 2 && exp_ov && stall < 5);
         start     = mode == 1 && ($urandom % 8 == 0);
         cfg_num_ch = 8'($urandom); cfg_num_pix = 10'($urandom);
         #1;
         ir  = k < total && !(exp_ov && !out_ready);
         acc = in_valid && ir;
         chk("in_ready", in_ready, ir);
         chk("out_valid", out_valid, exp_ov);
         chk("relu_en", relu_en, relu_exp(exp_ov));
         chk("psum_we", psum_we, exp_we);
         if (exp_we) chk("psum_waddr", psum_waddr, exp_wa);
         chk("busy", busy, 1);
         chk("done_early", done, 0);
         c = k / np;
         p = k % np;
         chk("add_mode", add_mode, !acc ? 0 : c == ne - 1 ? 2 : c == 0 ? 0 : 1);
         chk("psum_clr", psum_clr, acc && c == 0);
         chk("psum_raddr", psum_raddr, acc ? p : 0);
         chk("psum_fwd", psum_fwd, acc && exp_we && exp_wa == 10'(p));
         if (mode == 2 && exp_ov && !out_ready) stall++;
         hs = exp_ov && out_ready;
         if (hs) hs_cnt++;
         exp_ov = (acc && c == ne - 1) || (exp_ov && !out_ready);
         exp_we = acc && c != ne - 1;
         exp_wa = exp_we ? 10'(p) : 10'd0;
         if (acc) k++;
         @(negedge clk);
      end
      start = 0; in_valid = 0;
      #1;
      chk("tile_timeout", cyc < 4000, 1);
      chk("results", hs_cnt, np);
      chk("done", done, 1);
      chk("busy_at_done", busy, 0);
      chk("out_valid_at_done", out_valid, 0);
      @(negedge clk);
      #1;
      idle_checks("after_done");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      idle_checks("reset");
      rst = 0;
      run_tile(1, 4, 0);
      run_tile(3, 2, 0);
      run_tile(4, 1, 0);
      run_tile(2, 3, 2);
      // abort at ch=1, pix=1 of a 2x3 tile
      @(negedge clk);
      start = 1; cfg_num_ch = 2; cfg_num_pix = 3; out_ready = 1;
      @(negedge clk);
      start = 0; in_valid = 1;
      repeat (4) @(negedge clk);
      in_valid = 0; rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      idle_checks("abort");
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("abort_no_done", done, 0);
         chk("abort_idle", busy, 0);
      end
      run_tile(2, 2, 0);
      run_tile(0, 0, 0);
      run_tile(4, 1, 1);
      repeat (6) run_tile($urandom_range(1, 5), $urandom_range(1, 6), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
